pid_responder: RTL and testbench
================================

# pid_responder

Consumes received-PID entries from the PID FIFO in arrival order and drives the USB transmitter with the matching reply. It answers OUT/SETUP data with ACK or NAK, and IN tokens with DATA0/DATA1 or NAK. It also tracks the OUT and IN data toggles and waits for the host ACK after each data packet. It sits between the receive-side PID FIFO and the transmit packet encoder, alongside the encrypted-data buffer.

## Interface
- TIMEOUT, default 16: cycles to wait for a data PID after a token, or for a host ACK after our data packet.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  PID FIFO has no entries
- fifo_r_data  in  8  PID FIFO head; show-ahead, valid whenever fifo_empty=0
- fifo_r_enable  out  1  pops the head at this clock edge
- tx_busy  in  1  transmitter is sending
- tx_start  out  1  one-cycle request to send the handshake or data packet named by tx_pid
- tx_pid  out  8  full PID byte to send; registered
- rx_buf_full  in  1  OUT data buffer cannot accept a packet
- enc_ready  in  1  one encrypted block is ready for an IN transfer
- enc_consume  out  1  one-cycle pulse: the block was ACKed by the host and may be released
- pid_err  out  1  one-cycle pulse: invalid or unexpected PID was dropped
- out_toggle  out  1  expected DATA toggle for OUT/SETUP data
- in_toggle  out  1  toggle of the next IN data packet

## Operation
- PID constants (byte form {~pid[3:0], pid[3:0]}):
  - tokens: OUT 0xE1, IN 0x69, SETUP 0x2D
  - data: DATA0 0xC3, DATA1 0x4B
  - handshakes: ACK 0xD2, NAK 0x5A
- A byte whose upper nibble is not the complement of its lower nibble is invalid. It is popped, dropped and pulses pid_err.
- States: IDLE, DECODE, WAIT_DATA, SEND, TX_WAIT, WAIT_ACK.
- IDLE: when fifo_empty=0, pop (fifo_r_enable=1), latch the head into pid_reg, then go to DECODE.
- DECODE:
  - OUT: set token_pending=OUT, then WAIT_DATA.
  - SETUP: set token_pending=SETUP, force out_toggle=0, then WAIT_DATA.
  - IN: if enc_ready, send DATA0 or DATA1 per in_toggle and go to SEND; else send NAK and go to SEND.
  - DATA0/DATA1 with a token pending, rx_buf_full=1: send NAK; toggle unchanged.
  - DATA0/DATA1 with a token pending, toggle == out_toggle: send ACK, flip out_toggle.
  - DATA0/DATA1 with a token pending, toggle mismatch (retransmission): send ACK, toggle unchanged.
  - Pending token is cleared after any data PID.
  - DATA without a pending token, any handshake, or any other PID: pid_err, return to IDLE.
- WAIT_DATA: when fifo_empty=0, pop into pid_reg and go to DECODE; token_pending is still set. A new token arriving here replaces the pending one. If the timer expires first, clear token_pending and return to IDLE silently.
- SEND: assert tx_start only in a cycle where tx_busy=0, then go to TX_WAIT. tx_pid is loaded in DECODE and held until the next load.
- TX_WAIT: skip one cycle, then wait for tx_busy=0. After a DATA packet go to WAIT_ACK; otherwise go to IDLE.
- WAIT_ACK:
  - Head == ACK: pop it, flip in_toggle, pulse enc_consume, go to IDLE.
  - Any other head: do not pop; go to IDLE so that entry is processed normally. in_toggle is unchanged.
  - Timeout: go to IDLE, in_toggle unchanged; the host retries.
- Timer: counter of width $clog2(TIMEOUT+1). Cleared on entry to WAIT_DATA or WAIT_ACK. Expiry is the cycle the count reaches TIMEOUT while fifo_empty=1.
- A FIFO head present in the expiry cycle wins over the timeout.

## Timing
- Reset values:
  - all outputs 0: fifo_r_enable, tx_start, enc_consume, pid_err, tx_pid=0x00, out_toggle=0, in_toggle=0
  - state IDLE, token_pending cleared, timer 0
- Reset asserted mid-transfer aborts the transfer on the next edge; no further pulses are issued.
- Pop-to-reply latency: head popped in cycle n, DECODE in n+1, tx_start in n+2 if tx_busy=0. Each cycle tx_busy=1 stalls tx_start by one.
- fifo_r_enable is never asserted while fifo_empty=1, and for at most one cycle per entry.
- pid_err and enc_consume are single-cycle pulses, registered.

## Structure
- Shared package usb_pid_pkg holds:
  - the eight PID byte constants
  - the state enum
  - a function pid_valid(byte) that checks the nibble complement
- One sub-module, pid_timeout_timer, is natural: a clear-and-count counter with parameter TIMEOUT and output expired. The FSM and toggles live in pid_responder.

## Test plan
- Reset, then FIFO entries OUT 0xE1 and DATA0 0xC3, rx_buf_full=0 -> tx_start with tx_pid=0xD2 two cycles after the DATA0 pop; out_toggle goes 0 to 1.
- Repeat OUT + DATA0 with out_toggle=1 -> ACK 0xD2 sent, out_toggle stays 1; then SETUP + DATA0 -> ACK, out_toggle=1.
- IN 0x69, enc_ready=1, in_toggle=0 -> tx_pid=0xC3; then ACK 0xD2 enters the FIFO within 16 cycles -> popped, enc_consume pulse, in_toggle=1.
- IN with enc_ready=0 -> tx_pid=0x5A. IN, DATA sent, no ACK for 16 cycles -> return to IDLE, no enc_consume, in_toggle unchanged.
- Entry 0xC4 (bad check nibble) -> popped, one-cycle pid_err, no tx_start.
- Entry DATA1 with no token pending -> pid_err, no tx_start.
- OUT token, then timer expiry -> idle, no tx_start.
- tx_busy held high 5 cycles -> tx_start delayed 5 cycles, tx_pid stable throughout.

Source files
------------

// File: rtl/usb_pid_pkg.sv
// rtl/usb_pid_pkg.sv - USB PID byte constants, responder state encoding and PID check helper
package usb_pid_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_DATA,
        ST_SEND,
        ST_TX_WAIT,
        ST_WAIT_ACK
    } state_t;

    typedef enum logic [1:0] {
        TOK_NONE,
        TOK_OUT,
        TOK_SETUP
    } token_t;

    // Upper nibble must be the bitwise complement of the lower nibble.
    function automatic logic pid_valid(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/pid_timeout_timer.sv
// rtl/pid_timeout_timer.sv - clear-and-count timer that saturates and flags expiry at TIMEOUT
module pid_timeout_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/pid_responder.sv
// rtl/pid_responder.sv - pops received PIDs and drives the transmitter with handshakes or IN data
module pid_responder
    import usb_pid_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_r_data,
    output logic       fifo_r_enable,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_pid,
    input  logic       rx_buf_full,
    input  logic       enc_ready,
    output logic       enc_consume,
    output logic       pid_err,
    output logic       out_toggle,
    output logic       in_toggle
);

    state_t     state, state_next;
    token_t     token, token_next;
    logic [7:0] pid_reg;
    logic [7:0] tx_pid_next;
    logic       out_toggle_next, in_toggle_next;
    logic       sent_data, sent_data_next;
    logic       skip_done, skip_done_next;
    logic       pid_err_next, enc_consume_next;
    logic       fifo_pop, tx_start_req;
    logic       timer_clear, expired;
    logic       data_bit;

    assign data_bit    = (pid_reg == PID_DATA1);
    assign timer_clear = !(state == ST_WAIT_DATA || state == ST_WAIT_ACK);

    pid_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .expired(expired)
    );

    always_comb begin
        state_next       = state;
        token_next       = token;
        tx_pid_next      = tx_pid;
        out_toggle_next  = out_toggle;
        in_toggle_next   = in_toggle;
        sent_data_next   = sent_data;
        skip_done_next   = skip_done;
        pid_err_next     = 1'b0;
        enc_consume_next = 1'b0;
        fifo_pop         = 1'b0;
        tx_start_req     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (!pid_valid(pid_reg)) begin
                    pid_err_next = 1'b1;
                    token_next   = TOK_NONE;
                    state_next   = ST_IDLE;
                end else begin
                    case (pid_reg)
                        PID_OUT: begin
                            token_next = TOK_OUT;
                            state_next = ST_WAIT_DATA;
                        end
                        PID_SETUP: begin
                            token_next      = TOK_SETUP;
                            out_toggle_next = 1'b0;
                            state_next      = ST_WAIT_DATA;
                        end
                        PID_IN: begin
                            token_next     = TOK_NONE;
                            sent_data_next = enc_ready;
                            if (enc_ready) begin
                                tx_pid_next = in_toggle ? PID_DATA1 : PID_DATA0;
                            end else begin
                                tx_pid_next = PID_NAK;
                            end
                            state_next = ST_SEND;
                        end
                        PID_DATA0, PID_DATA1: begin
                            if (token != TOK_NONE) begin
                                token_next     = TOK_NONE;
                                sent_data_next = 1'b0;
                                state_next     = ST_SEND;
                                if (rx_buf_full) begin
                                    tx_pid_next = PID_NAK;
                                end else begin
                                    // A repeated toggle is a retransmission: ACK it but keep the toggle.
                                    tx_pid_next = PID_ACK;
                                    if (data_bit == out_toggle) begin
                                        out_toggle_next = ~out_toggle;
                                    end
                                end
                            end else begin
                                pid_err_next = 1'b1;
                                state_next   = ST_IDLE;
                            end
                        end
                        default: begin
                            pid_err_next = 1'b1;
                            token_next   = TOK_NONE;
                            state_next   = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_WAIT_DATA: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_DECODE;
                end else if (expired) begin
                    token_next = TOK_NONE;
                    state_next = ST_IDLE;
                end
            end

            ST_SEND: begin
                skip_done_next = 1'b0;
                if (!tx_busy) begin
                    tx_start_req = 1'b1;
                    state_next   = ST_TX_WAIT;
                end
            end

            ST_TX_WAIT: begin
                // The transmitter raises busy one cycle after the start request.
                if (!skip_done) begin
                    skip_done_next = 1'b1;
                end else if (!tx_busy) begin
                    state_next = sent_data ? ST_WAIT_ACK : ST_IDLE;
                end
            end

            ST_WAIT_ACK: begin
                if (!fifo_empty) begin
                    if (fifo_r_data == PID_ACK) begin
                        fifo_pop         = 1'b1;
                        in_toggle_next   = ~in_toggle;
                        enc_consume_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end else if (expired) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fifo_r_enable = fifo_pop & ~rst;
    assign tx_start      = tx_start_req & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            token       <= TOK_NONE;
            pid_reg     <= '0;
            tx_pid      <= '0;
            out_toggle  <= 1'b0;
            in_toggle   <= 1'b0;
            sent_data   <= 1'b0;
            skip_done   <= 1'b0;
            pid_err     <= 1'b0;
            enc_consume <= 1'b0;
        end else begin
            state       <= state_next;
            token       <= token_next;
            tx_pid      <= tx_pid_next;
            out_toggle  <= out_toggle_next;
            in_toggle   <= in_toggle_next;
            sent_data   <= sent_data_next;
            skip_done   <= skip_done_next;
            pid_err     <= pid_err_next;
            enc_consume <= enc_consume_next;
            if (fifo_pop) begin
                pid_reg <= fifo_r_data;
            end
        end
    end

endmodule

// File: tb/tb_pid_responder.sv
// tb/tb_pid_responder.sv - scoreboard bench for pid_responder with a transaction-level reference model
module tb_pid_responder;
    import usb_pid_pkg::*;

    localparam int EV_TX  = 0;
    localparam int EV_ERR = 1;
    localparam int EV_CON = 2;

    typedef struct {
        int         kind;
        logic [7:0] pid;
    } ev_t;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       fifo_empty  = 1'b1;
    logic [7:0] fifo_r_data = 8'h00;
    logic       force_busy  = 1'b0;
    logic       rx_buf_full = 1'b0;
    logic       enc_ready   = 1'b0;
    logic       tx_busy;
    logic       fifo_r_enable, tx_start, enc_consume, pid_err, out_toggle, in_toggle;
    logic [7:0] tx_pid;

    logic [7:0] fq[$];
    ev_t        exp_q[$];
    logic [7:0] orphans[4] = '{PID_DATA0, PID_DATA1, PID_ACK, PID_NAK};

    int n_tests = 0, n_fail = 0;
    int cyc = 0, pop_cyc = 0, last_tx_cyc = 0, tx_cnt = 0;
    bit start_flag = 1'b0, will_pop = 1'b0;
    bit m_out = 1'b0, m_in = 1'b0;

    assign tx_busy = force_busy | (tx_cnt != 0);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pid_responder #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_enable(fifo_r_enable),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_pid       (tx_pid),
        .rx_buf_full  (rx_buf_full),
        .enc_ready    (enc_ready),
        .enc_consume  (enc_consume),
        .pid_err      (pid_err),
        .out_toggle   (out_toggle),
        .in_toggle    (in_toggle)
    );

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty  = (fq.size() == 0);
        fifo_r_data = fifo_empty ? 8'h00 : fq[0];
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_sync();
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] pid);
        ev_t e;
        e.kind = kind;
        e.pid  = pid;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic got(input int kind, input logic [7:0] pid);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d pid %02h, expected no event", kind, pid);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.pid != pid) begin
                n_fail++;
                $display("FAIL event: got kind %0d pid %02h, expected kind %0d pid %02h",
                         kind, pid, e.kind, e.pid);
            end
        end
    endtask

    // Monitor: samples after the stimulus update of the same cycle.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (tx_start) begin
                last_tx_cyc = cyc;
                start_flag  = 1'b1;
                check("tx_start_while_busy", int'(tx_busy), 0);
                got(EV_TX, tx_pid);
            end
            if (pid_err)     got(EV_ERR, 8'h00);
            if (enc_consume) got(EV_CON, 8'h00);
        end
    end

    // Transmitter model: busy for three cycles after each start.
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            tx_cnt     = 0;
            start_flag = 1'b0;
        end else if (start_flag) begin
            tx_cnt     = 3;
            start_flag = 1'b0;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
    end

    // FIFO model: the pop request seen just before the edge removes the head.
    always begin
        @(negedge clk);
        #4;
        will_pop = fifo_r_enable;
        if (will_pop) begin
            pop_cyc = cyc;
            check("pop_while_empty", int'(fifo_empty), 0);
        end
        @(posedge clk);
        #1;
        if (will_pop && fq.size() != 0) begin
            void'(fq.pop_front());
            fifo_sync();
        end
    end

    function automatic logic [7:0] bad_byte();
        int b;
        do b = int'($urandom_range(0, 255)); while (((b >> 4) ^ (b & 15)) == 15);
        return 8'(b);
    endfunction

    task automatic settle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step(1);
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_events: %0d outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        step(40);
        check({name, "_out_toggle"}, int'(out_toggle), int'(m_out));
        check({name, "_in_toggle"}, int'(in_toggle), int'(m_in));
        check({name, "_fifo_drained"}, fq.size(), 0);
    endtask

    task automatic txn_out(input bit setup, input bit t, input bit full, input int busy);
        rx_buf_full = full;
        if (setup) m_out = 1'b0;
        if (full) begin
            expect_ev(EV_TX, PID_NAK);
        end else begin
            expect_ev(EV_TX, PID_ACK);
            if (t == m_out) m_out = ~m_out;
        end
        if (busy > 0) force_busy = 1'b1;
        push(setup ? PID_SETUP : PID_OUT);
        push(t ? PID_DATA1 : PID_DATA0);
        if (busy > 0) begin
            step(busy);
            force_busy = 1'b0;
        end
        settle(setup ? "setup_data" : "out_data");
    endtask

    // host: 0 = ACK, 1 = silence, 2 = unrelated bad byte
    task automatic txn_in(input bit ready, input int host);
        enc_ready = ready;
        push(PID_IN);
        if (!ready) begin
            expect_ev(EV_TX, PID_NAK);
        end else begin
            expect_ev(EV_TX, m_in ? PID_DATA1 : PID_DATA0);
            if (host == 0) begin
                expect_ev(EV_CON, 8'h00);
                m_in = ~m_in;
                push(PID_ACK);
            end else if (host == 2) begin
                expect_ev(EV_ERR, 8'h00);
                push(bad_byte());
            end
        end
        settle("in");
    endtask

    task automatic txn_err(input logic [7:0] b);
        expect_ev(EV_ERR, 8'h00);
        push(b);
        settle("pid_err");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(3);
        check("rst_fifo_r_enable", int'(fifo_r_enable), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_enc_consume", int'(enc_consume), 0);
        check("rst_pid_err", int'(pid_err), 0);
        check("rst_tx_pid", int'(tx_pid), 0);
        check("rst_out_toggle", int'(out_toggle), 0);
        check("rst_in_toggle", int'(in_toggle), 0);
        rst = 1'b0;
        step(2);

        txn_out(1'b0, 1'b0, 1'b0, 0);
        check("ack_latency", last_tx_cyc - pop_cyc, 2);
        txn_out(1'b0, 1'b0, 1'b0, 0);
        txn_out(1'b1, 1'b0, 1'b0, 0);
        txn_in(1'b1, 0);
        txn_in(1'b0, 0);
        txn_in(1'b1, 1);
        txn_in(1'b1, 2);
        txn_err(8'hC4);
        txn_err(PID_DATA1);
        push(PID_OUT);
        settle("out_timeout");
        txn_err(PID_DATA0);
        txn_out(1'b0, 1'b1, 1'b1, 0);

        // Transmitter busy for the five cycles the reply would otherwise start in.
        rx_buf_full = 1'b0;
        expect_ev(EV_TX, PID_ACK);
        if (m_out == 1'b0) m_out = 1'b1;
        force_busy = 1'b1;
        push(PID_OUT);
        push(PID_DATA0);
        step(4);
        for (int i = 0; i < 5; i++) begin
            check("stall_tx_pid", int'(tx_pid), int'(PID_ACK));
            check("stall_no_start", int'(tx_start), 0);
            step(1);
        end
        force_busy = 1'b0;
        settle("busy");
        check("busy_latency", last_tx_cyc - pop_cyc, 7);

        // Reset while the reply is stalled in the transmitter queue.
        force_busy = 1'b1;
        push(PID_OUT);
        push(PID_DATA0);
        step(6);
        rst = 1'b1;
        fq.delete();
        fifo_sync();
        force_busy = 1'b0;
        step(2);
        rst   = 1'b0;
        m_out = 1'b0;
        m_in  = 1'b0;
        settle("reset_abort");

        for (int i = 0; i < 40; i++) begin
            int k;
            k = int'($urandom_range(0, 5));
            case (k)
                0, 1: txn_out(k == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                              int'($urandom_range(0, 6)));
                2: txn_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 2)));
                3: txn_err(bad_byte());
                4: txn_err(orphans[$urandom_range(0, 3)]);
                default: begin
                    push(PID_OUT);
                    settle("rand_timeout");
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
